// File: rtl/reg_flag_file_if.sv
// Register-file / flag bus: two read ports, one write port, flag update and branch decode.
interface reg_flag_file_if;
    logic [3:0]  src1_sel;
    logic [3:0]  src2_sel;
    logic [3:0]  dst_sel;
    logic        wr_en;
    logic [15:0] dst_data;
    logic [15:0] src1_data;
    logic [15:0] src2_data;
    logic        flag_we;
    logic [2:0]  flag_next;
    logic [2:0]  flags;
    logic [2:0]  cond;
    logic        br_taken;

    modport master (
        output src1_sel, src2_sel, dst_sel, wr_en, dst_data, flag_we, flag_next, cond,
        input  src1_data, src2_data, flags, br_taken
    );
    modport slave (
        input  src1_sel, src2_sel, dst_sel, wr_en, dst_data, flag_we, flag_next, cond,
        output src1_data, src2_data, flags, br_taken
    );
endinterface

// File: rtl/reg_flag_file.sv
// 16x16 register file with R0 hardwired to zero, optional write-through forwarding,
// a 3-bit NVZ flag register and branch-condition decode.
module reg_flag_rd_port #(
    parameter bit BYPASS   = 1'b1,
    parameter int VEC_W    = 16,
    parameter int NUM_REGS = 16
) (
    input  logic [NUM_REGS-1:0][VEC_W-1:0] regs,
    input  logic [3:0]                     sel,
    input  logic [3:0]                     dst_sel,
    input  logic                           wr_en,
    input  logic [VEC_W-1:0]               dst_data,
    output logic [VEC_W-1:0]               data
);
    logic fwd;

    // Forwarding never fires for R0, so a discarded R0 write cannot leak out.
    assign fwd  = BYPASS && wr_en && (dst_sel != 4'd0) && (dst_sel == sel);
    assign data = fwd ? dst_data : ((sel == 4'd0) ? '0 : regs[sel]);
endmodule

module reg_flag_file #(
    parameter bit BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    reg_flag_file_if.slave bus
);
    localparam int NUM_RD   = 2;
    localparam int VEC_W    = 16;
    localparam int NUM_REGS = 16;

    logic [NUM_REGS-1:0][VEC_W-1:0] regs;
    logic [2:0]                     flags_q;
    logic [NUM_RD-1:0][3:0]         rd_sel;
    logic [NUM_RD-1:0][VEC_W-1:0]   rd_data;

    assign rd_sel        = {bus.src2_sel, bus.src1_sel};
    assign bus.src1_data = rd_data[0];
    assign bus.src2_data = rd_data[1];
    assign bus.flags     = flags_q;

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            reg_flag_rd_port #(.BYPASS(BYPASS), .VEC_W(VEC_W), .NUM_REGS(NUM_REGS)) u_rd (
                .regs     (regs),
                .sel      (rd_sel[g]),
                .dst_sel  (bus.dst_sel),
                .wr_en    (bus.wr_en),
                .dst_data (bus.dst_data),
                .data     (rd_data[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            flags_q <= 3'b000;
        end else begin
            if (bus.wr_en && (bus.dst_sel != 4'd0))
                regs[bus.dst_sel] <= bus.dst_data;
            if (bus.flag_we)
                flags_q <= bus.flag_next;
        end
    end

    // flags_q = {Z, V, N}
    always_comb begin
        bus.br_taken = 1'b0;
        case (bus.cond)
            3'b000: bus.br_taken = ~flags_q[2];
            3'b001: bus.br_taken =  flags_q[2];
            3'b010: bus.br_taken = ~flags_q[2] & ~flags_q[0];
            3'b011: bus.br_taken =  flags_q[0];
            3'b100: bus.br_taken =  flags_q[2] | ~flags_q[0];
            3'b101: bus.br_taken =  flags_q[0] |  flags_q[2];
            3'b110: bus.br_taken =  flags_q[1];
            default: bus.br_taken = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_reg_flag_file.sv
// Directed bench for reg_flag_file: a BYPASS=1 DUT plus a BYPASS=0 twin on the same inputs.
module tb_reg_flag_file;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_flag_file_if bus ();
    reg_flag_file_if bus0 ();

    reg_flag_file #(.BYPASS(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    reg_flag_file #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus0.src1_sel  = bus.src1_sel;
    assign bus0.src2_sel  = bus.src2_sel;
    assign bus0.dst_sel   = bus.dst_sel;
    assign bus0.wr_en     = bus.wr_en;
    assign bus0.dst_data  = bus.dst_data;
    assign bus0.flag_we   = bus.flag_we;
    assign bus0.flag_next = bus.flag_next;
    assign bus0.cond      = bus.cond;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_br(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[0]; v = f[1]; z = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.src1_sel = 4'd4; bus.src2_sel = 4'd9; bus.dst_sel = 4'd0; bus.wr_en = 1'b0;
        bus.dst_data = 16'h0; bus.flag_we = 1'b0; bus.flag_next = 3'b000; bus.cond = 3'b000;
        #2;
        n_checks++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", bus.flags); end
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL reset_src1 got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'h0) begin n_fail++; $display("FAIL reset_src2 got %h want 0000", bus.src2_data); end
        for (int c = 0; c < 8; c++) begin
            bus.cond = 3'(c);
            #1;
            n_checks++;
            if (bus.br_taken !== ((c == 0) || (c == 2) || (c == 4) || (c == 7))) begin
                n_fail++; $display("FAIL reset_br cond=%0d got %b", c, bus.br_taken);
            end
        end
        // forwarding path stays live during reset; the edge-time write must be dropped
        bus.wr_en = 1'b1; bus.dst_sel = 4'd4; bus.dst_data = 16'h1234;
        bus.flag_we = 1'b1; bus.flag_next = 3'b111;
        #1;
        n_checks++; if (bus.src1_data !== 16'h1234) begin n_fail++; $display("FAIL reset_fwd got %h want 1234", bus.src1_data); end
        n_checks++; if (bus0.src1_data !== 16'h0) begin n_fail++; $display("FAIL reset_nofwd got %h want 0000", bus0.src1_data); end
        tick();
        bus.wr_en = 1'b0; bus.flag_we = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL reset_write_dropped got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL reset_flag_dropped got %b want 000", bus.flags); end
        tick();
    endtask

    task automatic test_write_read();
        bus.wr_en = 1'b1; bus.dst_sel = 4'd5; bus.dst_data = 16'hBEEF;
        bus.src1_sel = 4'd0; bus.src2_sel = 4'd0;
        tick();
        bus.wr_en = 1'b0; bus.src1_sel = 4'd5; bus.src2_sel = 4'd5;
        #1;
        n_checks++; if (bus.src1_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_src1 got %h want beef", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_src2 got %h want beef", bus.src2_data); end
        n_checks++; if (bus0.src1_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_nobyp got %h want beef", bus0.src1_data); end
    endtask

    task automatic test_r0_guard();
        bus.wr_en = 1'b1; bus.dst_sel = 4'd0; bus.dst_data = 16'hFFFF;
        bus.src1_sel = 4'd0; bus.src2_sel = 4'd0;
        #1;
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL r0_fwd_src1 got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'h0) begin n_fail++; $display("FAIL r0_fwd_src2 got %h want 0000", bus.src2_data); end
        tick();
        bus.wr_en = 1'b0;
        #1;
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL r0_store_src1 got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'h0) begin n_fail++; $display("FAIL r0_store_src2 got %h want 0000", bus.src2_data); end
    endtask

    task automatic test_forward();
        bus.wr_en = 1'b1; bus.dst_sel = 4'd3; bus.dst_data = 16'h0001;
        tick();
        bus.dst_data = 16'h1234; bus.src1_sel = 4'd3; bus.src2_sel = 4'd3;
        #1;
        n_checks++; if (bus.src1_data !== 16'h1234) begin n_fail++; $display("FAIL fwd_src1 got %h want 1234", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'h1234) begin n_fail++; $display("FAIL fwd_src2 got %h want 1234", bus.src2_data); end
        n_checks++; if (bus0.src1_data !== 16'h0001) begin n_fail++; $display("FAIL nobyp_src1 got %h want 0001", bus0.src1_data); end
        bus.src2_sel = 4'd5;
        #1;
        n_checks++; if (bus.src1_data !== 16'h1234) begin n_fail++; $display("FAIL fwd_indep_src1 got %h want 1234", bus.src1_data); end
        n_checks++; if (bus.src2_data !== 16'hBEEF) begin n_fail++; $display("FAIL fwd_indep_src2 got %h want beef", bus.src2_data); end
        tick();
        bus.wr_en = 1'b0; bus.src2_sel = 4'd3;
        #1;
        n_checks++; if (bus0.src2_data !== 16'h1234) begin n_fail++; $display("FAIL fwd_stored got %h want 1234", bus0.src2_data); end
    endtask

    task automatic test_flags();
        bus.flag_we = 1'b1; bus.flag_next = 3'b100;
        tick();
        bus.flag_we = 1'b0; bus.flag_next = 3'b011;
        tick();
        n_checks++; if (bus.flags !== 3'b100) begin n_fail++; $display("FAIL flag_hold got %b want 100", bus.flags); end
        bus.cond = 3'b001; #1;
        n_checks++; if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL flag_eq got %b want 1", bus.br_taken); end
        bus.cond = 3'b000; #1;
        n_checks++; if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL flag_ne got %b want 0", bus.br_taken); end
        // unknowns on disabled ports must not disturb state
        bus.flag_next = 3'bxxx; bus.dst_sel = 4'bxxxx; bus.dst_data = 16'hxxxx; bus.src1_sel = 4'd5;
        tick();
        n_checks++; if (bus.flags !== 3'b100) begin n_fail++; $display("FAIL flag_x_hold got %b want 100", bus.flags); end
        n_checks++; if (bus.src1_data !== 16'hBEEF) begin n_fail++; $display("FAIL reg_x_hold got %h want beef", bus.src1_data); end
        bus.dst_sel = 4'd0; bus.dst_data = 16'h0; bus.flag_next = 3'b000;
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 8; f++) begin
            bus.flag_we = 1'b1; bus.flag_next = 3'(f);
            tick();
            bus.flag_we = 1'b0;
            n_checks++; if (bus.flags !== 3'(f)) begin n_fail++; $display("FAIL sweep_flags got %b want %b", bus.flags, 3'(f)); end
            for (int c = 0; c < 8; c++) begin
                bus.cond = 3'(c);
                #1;
                n_checks++;
                if (bus.br_taken !== exp_br(3'(c), 3'(f))) begin
                    n_fail++; $display("FAIL sweep_br cond=%0d flags=%b got %b want %b", c, 3'(f), bus.br_taken, exp_br(3'(c), 3'(f)));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.wr_en = 1'b1; bus.dst_sel = 4'd9; bus.dst_data = 16'h5A5A;
        bus.flag_we = 1'b1; bus.flag_next = 3'b010;
        tick();
        bus.wr_en = 1'b0; bus.flag_we = 1'b0; bus.src1_sel = 4'd9;
        #1;
        n_checks++; if (bus.src1_data !== 16'h5A5A) begin n_fail++; $display("FAIL simul_reg got %h want 5a5a", bus.src1_data); end
        n_checks++; if (bus.flags !== 3'b010) begin n_fail++; $display("FAIL simul_flags got %b want 010", bus.flags); end
    endtask

    task automatic test_async_reset();
        bus.wr_en = 1'b1; bus.dst_sel = 4'd7; bus.dst_data = 16'hA5A5;
        bus.flag_we = 1'b1; bus.flag_next = 3'b111;
        tick();
        bus.wr_en = 1'b0; bus.flag_we = 1'b0; bus.src1_sel = 4'd7; bus.cond = 3'b000;
        #1;
        n_checks++; if (bus.src1_data !== 16'hA5A5) begin n_fail++; $display("FAIL pre_rst_r7 got %h want a5a5", bus.src1_data); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL async_r7 got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL async_flags got %b want 000", bus.flags); end
        n_checks++; if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL async_br_ne got %b want 1", bus.br_taken); end
        bus.wr_en = 1'b1; bus.dst_data = 16'h1111; bus.flag_we = 1'b1; bus.flag_next = 3'b111; bus.src1_sel = 4'd0;
        tick();
        bus.wr_en = 1'b0; bus.flag_we = 1'b0; bus.src1_sel = 4'd7;
        #1;
        n_checks++; if (bus.src1_data !== 16'h0) begin n_fail++; $display("FAIL rst_write_ignored got %h want 0000", bus.src1_data); end
        n_checks++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL rst_flag_ignored got %b want 000", bus.flags); end
        #2 rst_n = 1'b1;
        bus.wr_en = 1'b1; bus.dst_data = 16'h2222;
        tick();
        bus.wr_en = 1'b0;
        #1;
        n_checks++; if (bus.src1_data !== 16'h2222) begin n_fail++; $display("FAIL post_rst_write got %h want 2222", bus.src1_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0_guard();
        test_forward();
        test_flags();
        test_cond_sweep();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
